// File: rtl/rd_hazard_tracker_pkg.sv
// Shared types for the decode-side destination-register tracker.
// One entry describes a single in-flight instruction's register-file write.
package rd_hazard_tracker_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_X0 = '0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic                  we;
  } trk_entry_t;

  localparam trk_entry_t TRK_EMPTY = '{rd: REG_X0, we: 1'b0};

endpackage

// File: rtl/rd_tracker_pipe.sv
// DEPTH-slot delay line of tracker entries; slot 0 is EX, slot DEPTH-1 is WB.
// Always shifts, never holds: the tracker drains even while ID is stalled.
module rd_tracker_pipe
  import rd_hazard_tracker_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  trk_entry_t             slot0_in,
  output trk_entry_t [DEPTH-1:0] slots
);

  trk_entry_t [DEPTH-1:0] slots_q, slots_d;

  always_comb begin
    slots_d    = slots_q;
    slots_d[0] = slot0_in;
    for (int i = 1; i < DEPTH; i++) slots_d[i] = slots_q[i-1];
  end

  always_ff @(posedge clk) begin
    if (!reset) slots_q <= {DEPTH{TRK_EMPTY}};
    else        slots_q <= slots_d;
  end

  assign slots = slots_q;

endmodule

// File: rtl/rd_hazard_tracker.sv
// RAW hazard detection for a forwarding-less pipeline: compares ID operands
// against in-flight destinations and drives the delayed register-file write.
module rd_hazard_tracker #(
  parameter int REG_ADDR_W = 5,
  parameter int DEPTH      = 3,
  parameter int WB_BYPASS  = 0,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic                  id_rs1_used,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_rd_we,
  input  logic                  flush,
  output logic                  stall,
  output logic                  bubble,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic                  wb_we,
  output logic [CNT_W-1:0]      stall_cnt
);
  import rd_hazard_tracker_pkg::*;

  // A write-first register file resolves the WB slot itself.
  localparam int MATCH_SLOTS = (WB_BYPASS != 0) ? DEPTH - 1 : DEPTH;

  trk_entry_t [DEPTH-1:0] slots;
  trk_entry_t             slot0_in;
  logic                   id_live, rs1_hit, rs2_hit, hazard, issue;
  logic [CNT_W-1:0]       stall_cnt_q, stall_cnt_d;

  rd_tracker_pipe #(.DEPTH(DEPTH)) u_pipe (
    .clk      (clk),
    .reset    (reset),
    .slot0_in (slot0_in),
    .slots    (slots)
  );

  always_comb begin
    rs1_hit = 1'b0;
    rs2_hit = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (k < MATCH_SLOTS && slots[k].we) begin
        if (slots[k].rd == id_rs1) rs1_hit = 1'b1;
        if (slots[k].rd == id_rs2) rs2_hit = 1'b1;
      end
    end

    // Reset and flush both mask the ID instruction; flush wins over hazard.
    id_live = reset & id_valid & ~flush;
    hazard  = id_live &
              ((id_rs1_used & (id_rs1 != REG_X0) & rs1_hit) |
               (id_rs2_used & (id_rs2 != REG_X0) & rs2_hit));
    issue   = id_live & ~hazard;

    slot0_in.rd = issue ? id_rd : REG_X0;
    slot0_in.we = issue & id_rd_we & (id_rd != REG_X0);

    stall_cnt_d = stall_cnt_q;
    if (hazard && stall_cnt_q != {CNT_W{1'b1}}) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall     = hazard;
  assign bubble    = ~issue;
  assign wb_rd     = slots[DEPTH-1].rd;
  assign wb_we     = slots[DEPTH-1].we;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_rd_hazard_tracker.sv
// Directed bench: a default instance, a write-first (WB_BYPASS=1) instance and
// a 2-bit counter instance, all sharing one ID-stage stimulus.
module tb_rd_hazard_tracker;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid, id_rs1_used, id_rs2_used, id_rd_we, flush;
  logic [4:0] id_rs1, id_rs2, id_rd;

  logic       s0, b0, we0, s1, b1, we1, s2, b2, we2;
  logic [4:0] wr0, wr1, wr2;
  logic [15:0] c0, c1;
  logic [1:0]  c2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rd_hazard_tracker u0 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs1_used(id_rs1_used),
    .id_rs2(id_rs2), .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_rd_we(id_rd_we), .flush(flush),
    .stall(s0), .bubble(b0), .wb_rd(wr0), .wb_we(we0), .stall_cnt(c0));

  rd_hazard_tracker #(.WB_BYPASS(1)) u1 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs1_used(id_rs1_used),
    .id_rs2(id_rs2), .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_rd_we(id_rd_we), .flush(flush),
    .stall(s1), .bubble(b1), .wb_rd(wr1), .wb_we(we1), .stall_cnt(c1));

  rd_hazard_tracker #(.CNT_W(2)) u2 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs1_used(id_rs1_used),
    .id_rs2(id_rs2), .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_rd_we(id_rd_we), .flush(flush),
    .stall(s2), .bubble(b2), .wb_rd(wr2), .wb_we(we2), .stall_cnt(c2));

  typedef struct {
    logic rst, v;
    logic [4:0] rs1; logic u1;
    logic [4:0] rs2; logic u2;
    logic [4:0] rd;  logic we, fl;
    logic e_stall, e_bub;
    logic [4:0] e_wbrd; logic e_wbwe;
    int e_cnt;
  } vec_t;

  function automatic vec_t mk(logic rst, logic v, logic [4:0] rs1, logic u1, logic [4:0] rs2,
                              logic u2, logic [4:0] rd, logic we, logic fl, logic st, logic bb,
                              logic [4:0] wrd, logic wwe, int cnt);
    vec_t r;
    r.rst = rst; r.v = v; r.rs1 = rs1; r.u1 = u1; r.rs2 = rs2; r.u2 = u2;
    r.rd = rd; r.we = we; r.fl = fl; r.e_stall = st; r.e_bub = bb;
    r.e_wbrd = wrd; r.e_wbwe = wwe; r.e_cnt = cnt;
    return r;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of ID inputs at the falling edge, then let comb settle.
  task automatic step(logic rst, logic v, logic [4:0] rs1, logic u1, logic [4:0] rs2, logic u2,
                      logic [4:0] rd, logic we, logic fl);
    @(negedge clk);
    reset = rst; id_valid = v; id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2;
    id_rs2_used = u2; id_rd = rd; id_rd_we = we; flush = fl;
    #1;
  endtask

  vec_t tbl[25];

  initial begin
    // Row fields: rst v rs1 u1 rs2 u2 rd we fl | stall bubble wb_rd wb_we cnt
    for (int i = 0; i < 3; i++) tbl[i] = mk(0,1,5,1,0,0,5,1,0, 0,1,0,0,0);
    tbl[3]  = mk(1,1,0,0,0,0,5,1,0, 0,0,0,0,0);   // producer x5
    tbl[4]  = mk(1,1,5,1,0,0,6,1,0, 1,1,0,0,0);   // consumer of x5 stalls
    tbl[5]  = mk(1,1,5,1,0,0,6,1,0, 1,1,0,0,1);
    tbl[6]  = mk(1,1,5,1,0,0,6,1,0, 1,1,5,1,2);   // producer in WB
    tbl[7]  = mk(1,1,5,1,0,0,6,1,0, 0,0,0,0,3);   // consumer issues
    tbl[8]  = mk(1,0,0,0,0,0,0,0,0, 0,1,0,0,3);
    tbl[9]  = mk(1,0,0,0,0,0,0,0,0, 0,1,0,0,3);
    tbl[10] = mk(1,0,0,0,0,0,0,0,0, 0,1,6,1,3);
    tbl[11] = mk(1,1,0,0,0,0,0,1,0, 0,0,0,0,3);   // write to x0
    tbl[12] = mk(1,1,0,1,0,1,0,0,0, 0,0,0,0,3);   // reads x0
    tbl[13] = mk(1,0,0,0,0,0,0,0,0, 0,1,0,0,3);
    tbl[14] = mk(1,0,0,0,0,0,0,0,0, 0,1,0,0,3);   // x0 write reaches WB with we=0
    tbl[15] = mk(1,1,0,0,0,0,7,1,0, 0,0,0,0,3);   // producer x7
    tbl[16] = mk(1,1,3,1,7,0,8,0,0, 0,0,0,0,3);   // rs2=x7 unused
    tbl[17] = mk(1,1,0,0,7,1,0,0,0, 1,1,0,0,3);   // rs2=x7 used, match slot1
    tbl[18] = mk(1,1,0,0,7,1,0,0,0, 1,1,7,1,4);
    tbl[19] = mk(1,1,0,0,7,1,0,0,0, 0,0,8,0,5);
    tbl[20] = mk(1,1,0,0,0,0,5,1,0, 0,0,0,0,5);   // producer x5
    tbl[21] = mk(1,1,5,1,0,0,0,0,0, 1,1,0,0,5);
    tbl[22] = mk(1,1,5,1,0,0,0,0,1, 0,1,0,0,6);   // flush over hazard
    tbl[23] = mk(1,0,0,0,0,0,0,0,0, 0,1,5,1,6);   // producer still writes
    tbl[24] = mk(1,0,0,0,0,0,0,0,0, 0,1,0,0,6);

    step(0,0,0,0,0,0,0,0,0);
    for (int i = 0; i < 25; i++) begin
      vec_t r;
      r = tbl[i];
      step(r.rst, r.v, r.rs1, r.u1, r.rs2, r.u2, r.rd, r.we, r.fl);
      chk($sformatf("v%0d_stall", i),  s0,  r.e_stall);
      chk($sformatf("v%0d_bubble", i), b0,  r.e_bub);
      chk($sformatf("v%0d_wb_rd", i),  wr0, r.e_wbrd);
      chk($sformatf("v%0d_wb_we", i),  we0, r.e_wbwe);
      chk($sformatf("v%0d_cnt", i),    c0,  r.e_cnt);
    end

    // Write-first register file: WB slot does not stall.
    step(0,0,0,0,0,0,0,0,0);
    step(1,1,0,0,0,0,5,1,0);
    chk("byp_prod_bubble", b1, 0);
    step(1,1,5,1,0,0,0,0,0);
    chk("byp_t1_stall", s1, 1);
    step(1,1,5,1,0,0,0,0,0);
    chk("byp_t2_stall", s1, 1);
    step(1,1,5,1,0,0,0,0,0);
    chk("byp_t3_stall", s1, 0);
    chk("byp_t3_bubble", b1, 0);
    chk("byp_cnt", c1, 2);
    chk("nobyp_t3_stall", s0, 1);

    // Four back-to-back RAW stalls saturate the 2-bit counter.
    step(0,0,0,0,0,0,0,0,0);
    for (int r = 0; r < 4; r++) begin
      int n;
      step(1,1,0,0,0,0,5,1,0);
      step(1,1,5,1,0,0,0,0,0);
      n = 0;
      while (s2 && n < 8) begin
        step(1,1,5,1,0,0,0,0,0);
        n++;
      end
      chk($sformatf("sat_r%0d_len", r), n, 3);
    end
    chk("sat_cnt2", c2, 3);
    chk("sat_cnt16", c0, 12);

    // Reset in the middle of a stall drops the producer.
    step(1,1,0,0,0,0,9,1,0);
    step(1,1,9,1,0,0,0,0,0);
    chk("rst_mid_stall_before", s2, 1);
    step(0,1,9,1,0,0,0,0,0);
    chk("rst_mid_stall_forced", s2, 0);
    chk("rst_mid_bubble_forced", b2, 1);
    step(1,1,9,1,0,0,0,0,0);
    chk("rst_after_stall", s2, 0);
    chk("rst_after_bubble", b2, 0);
    chk("rst_after_cnt", c2, 0);
    chk("rst_after_wb_we", we2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
